// File: rtl/mips_pkg.sv
// Shared constants for the multi-cycle MIPS-subset core: opcodes, R-type
// funct codes, the 3-bit ALU operation encoding and the FSM state codes.
// Ports: none (package).
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef logic [3:0] state_t;

    localparam state_t S_IDLE   = 4'd0;
    localparam state_t S_FETCH  = 4'd1;
    localparam state_t S_DECODE = 4'd2;
    localparam state_t S_EXEC_R = 4'd3;
    localparam state_t S_EXEC_I = 4'd4;
    localparam state_t S_MEMADR = 4'd5;
    localparam state_t S_MEMRD  = 4'd6;
    localparam state_t S_MEMWR  = 4'd7;
    localparam state_t S_WB_ALU = 4'd8;
    localparam state_t S_WB_MEM = 4'd9;
    localparam state_t S_BRANCH = 4'd10;
    localparam state_t S_JUMP   = 4'd11;
    localparam state_t S_TRAP   = 4'd12;

    function automatic logic funct_legal(input logic [5:0] funct);
        return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
               (funct == FN_OR)  || (funct == FN_SLT);
    endfunction

    function automatic logic [2:0] funct_to_aluop(input logic [5:0] funct);
        case (funct)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mips_mc_fsm.sv
// Sequencer for the multi-cycle core: state register plus per-state control
// decode for the shared ALU, the unified memory port and the register file.
// Ports: clk/reset; opcode, funct from IR; mem_ready; alu_zero and alu_lo2
// from the ALU result; control strobes and selects out; retire, halted.
//
// state  | meaning
// IDLE   | one cycle after reset release
// FETCH  | read instruction at pc, wait for ready
// DECODE | latch A/B, branch target into ALUOut, dispatch
// EXEC_R | R-type ALU op
// EXEC_I | addi: A + signimm
// MEMADR | effective address, alignment check
// MEMRD  | load access, wait for ready
// MEMWR  | store access, retires on ready
// WB_ALU | write ALUOut to rd/rt, retire
// WB_MEM | write load data to rt, retire
// BRANCH | beq/bne resolve, retire
// JUMP   | j, retire
// TRAP   | halted until reset
module mips_mc_fsm #(
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    input  logic       alu_zero,
    input  logic [1:0] alu_lo2,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_we,
    output logic       ab_we,
    output logic       aluout_we,
    output logic       mdr_we,
    output logic       reg_we,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       alu_srca,
    output logic [1:0] alu_srcb,
    output logic [2:0] alu_op,
    output logic       retire,
    output logic       halted
);
    import mips_pkg::*;

    state_t state, state_nx;
    logic   op_legal;
    logic   taken;

    always_comb begin
        case (opcode)
            OP_RTYPE: op_legal = funct_legal(funct);
            OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: op_legal = 1'b1;
            default:  op_legal = 1'b0;
        endcase
    end

    assign taken  = (opcode == OP_BEQ) ? alu_zero : !alu_zero;
    assign halted = (state == S_TRAP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_we      = 1'b0;
        ab_we      = 1'b0;
        aluout_we  = 1'b0;
        mdr_we     = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 2'd0;
        alu_srca   = 1'b0;
        alu_srcb   = 2'd0;
        alu_op     = ALU_ADD;
        retire     = 1'b0;
        case (state)
            S_IDLE: state_nx = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we    = 1'b1;
                    state_nx = S_DECODE;
                end
            end
            S_DECODE: begin
                // ALUOut gets the branch target here so BRANCH only needs A-B.
                ab_we     = 1'b1;
                aluout_we = 1'b1;
                alu_srca  = 1'b1;
                alu_srcb  = 2'd2;
                if (!op_legal) begin
                    if (TRAP_ON_ILLEGAL) begin
                        state_nx = S_TRAP;
                    end else begin
                        pc_we    = 1'b1;
                        retire   = 1'b1;
                        state_nx = S_FETCH;
                    end
                end else begin
                    case (opcode)
                        OP_RTYPE:      state_nx = S_EXEC_R;
                        OP_ADDI:       state_nx = S_EXEC_I;
                        OP_LW, OP_SW:  state_nx = S_MEMADR;
                        OP_BEQ, OP_BNE: state_nx = S_BRANCH;
                        default:       state_nx = S_JUMP;
                    endcase
                end
            end
            S_EXEC_R: begin
                alu_op    = funct_to_aluop(funct);
                aluout_we = 1'b1;
                state_nx  = S_WB_ALU;
            end
            S_EXEC_I: begin
                alu_srcb  = 2'd1;
                aluout_we = 1'b1;
                state_nx  = S_WB_ALU;
            end
            S_MEMADR: begin
                alu_srcb  = 2'd1;
                aluout_we = 1'b1;
                if (alu_lo2 != 2'b00)     state_nx = S_TRAP;
                else if (opcode == OP_LW) state_nx = S_MEMRD;
                else                      state_nx = S_MEMWR;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    mdr_we   = 1'b1;
                    state_nx = S_WB_MEM;
                end
            end
            S_MEMWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    pc_we    = 1'b1;
                    retire   = 1'b1;
                    state_nx = S_FETCH;
                end
            end
            S_WB_ALU: begin
                reg_we   = 1'b1;
                reg_dst  = (opcode == OP_RTYPE);
                pc_we    = 1'b1;
                retire   = 1'b1;
                state_nx = S_FETCH;
            end
            S_WB_MEM: begin
                reg_we     = 1'b1;
                mem_to_reg = 1'b1;
                pc_we      = 1'b1;
                retire     = 1'b1;
                state_nx   = S_FETCH;
            end
            S_BRANCH: begin
                alu_op   = ALU_SUB;
                pc_src   = taken ? 2'd1 : 2'd0;
                pc_we    = 1'b1;
                retire   = 1'b1;
                state_nx = S_FETCH;
            end
            S_JUMP: begin
                pc_src   = 2'd2;
                pc_we    = 1'b1;
                retire   = 1'b1;
                state_nx = S_FETCH;
            end
            S_TRAP:  state_nx = S_TRAP;
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS-subset core: shared ALU, unified req/ready memory port,
// 32x32 register file, retire strobe and a combinational debug read port.
// Ports: clk, reset (async, active-high); mem_req/mem_we/mem_addr/mem_wdata
// out, mem_rdata/mem_ready in; pc, retire, halted status; dbg_ra in,
// dbg_rd out.
module mips_multicycle_core #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          ADDR_W          = 8,
    parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [31:0]       pc,
    output logic              retire,
    output logic              halted,
    input  logic [4:0]        dbg_ra,
    output logic [31:0]       dbg_rd
);
    import mips_pkg::*;

    localparam logic [ADDR_W-1:0] WORD_MASK = ~(ADDR_W'(3));

    logic [31:0] ir, a_q, b_q, aluout, mdr;
    logic [31:0] regs [32];
    logic [31:0] signimm, pc_plus4, pc_nx, alu_a, alu_b, alu_y, wr_data;
    logic [4:0]  wr_addr;
    logic [ADDR_W-1:0] addr_sel;

    logic       iord, ir_we, ab_we, aluout_we, mdr_we, reg_we, reg_dst, mem_to_reg;
    logic       pc_we, alu_srca;
    logic [1:0] pc_src, alu_srcb;
    logic [2:0] alu_op;

    mips_mc_fsm #(.TRAP_ON_ILLEGAL(TRAP_ON_ILLEGAL)) u_fsm (
        .clk        (clk),
        .reset      (reset),
        .opcode     (ir[31:26]),
        .funct      (ir[5:0]),
        .mem_ready  (mem_ready),
        .alu_zero   (alu_y == 32'd0),
        .alu_lo2    (alu_y[1:0]),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .ir_we      (ir_we),
        .ab_we      (ab_we),
        .aluout_we  (aluout_we),
        .mdr_we     (mdr_we),
        .reg_we     (reg_we),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .pc_we      (pc_we),
        .pc_src     (pc_src),
        .alu_srca   (alu_srca),
        .alu_srcb   (alu_srcb),
        .alu_op     (alu_op),
        .retire     (retire),
        .halted     (halted)
    );

    assign signimm  = {{16{ir[15]}}, ir[15:0]};
    assign pc_plus4 = pc + 32'd4;
    assign alu_a    = alu_srca ? pc_plus4 : a_q;

    always_comb begin
        case (alu_srcb)
            2'd1:    alu_b = signimm;
            2'd2:    alu_b = {signimm[29:0], 2'b00};
            default: alu_b = b_q;
        endcase
    end

    always_comb begin
        case (alu_op)
            ALU_AND: alu_y = alu_a & alu_b;
            ALU_OR:  alu_y = alu_a | alu_b;
            ALU_SUB: alu_y = alu_a - alu_b;
            ALU_SLT: alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
            default: alu_y = alu_a + alu_b;
        endcase
    end

    always_comb begin
        case (pc_src)
            2'd1:    pc_nx = aluout;
            2'd2:    pc_nx = {pc_plus4[31:28], ir[25:0], 2'b00};
            default: pc_nx = pc_plus4;
        endcase
    end

    assign wr_addr = reg_dst ? ir[15:11] : ir[20:16];
    assign wr_data = mem_to_reg ? mdr : aluout;

    // Data addresses reaching MEMRD/MEMWR are already aligned; masking keeps
    // the port word-aligned even for an odd RESET_PC.
    assign addr_sel  = iord ? aluout[ADDR_W-1:0] : pc[ADDR_W-1:0];
    assign mem_addr  = addr_sel & WORD_MASK;
    assign mem_wdata = b_q;

    assign dbg_rd = (dbg_ra == 5'd0) ? 32'd0 : regs[dbg_ra];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc     <= RESET_PC;
            ir     <= 32'd0;
            a_q    <= 32'd0;
            b_q    <= 32'd0;
            aluout <= 32'd0;
            mdr    <= 32'd0;
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else begin
            if (ir_we)     ir     <= mem_rdata;
            if (ab_we) begin
                a_q <= regs[ir[25:21]];
                b_q <= regs[ir[20:16]];
            end
            if (aluout_we) aluout <= alu_y;
            if (mdr_we)    mdr    <= mem_rdata;
            if (pc_we)     pc     <= pc_nx;
            if (reg_we && wr_addr != 5'd0) regs[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Self-checking bench for mips_multicycle_core: behavioural unified memory
// with programmable wait states on data accesses, retire/write scoreboards.
module tb_mips_multicycle_core;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_req, mem_we, mem_ready, retire, halted;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata, pc, dbg_rd;
    logic [4:0]  dbg_ra = 5'd0;

    logic [31:0] mem [64];
    assign mem_rdata = mem[mem_addr[7:2]];

    mips_multicycle_core #(.RESET_PC(32'h0), .ADDR_W(8), .TRAP_ON_ILLEGAL(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .pc        (pc),
        .retire    (retire),
        .halted    (halted),
        .dbg_ra    (dbg_ra),
        .dbg_rd    (dbg_rd)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int          exp_pc [$];
    int          exp_gap [$];
    logic [7:0]  exp_wa [$];
    logic [31:0] exp_wd [$];

    int          cyc = 0, last_ret = 0, wcnt = 0, data_waits = 0, data_reqs = 0;
    bit          sb_on = 1'b0, prev_stall = 1'b0, prev_we = 1'b0;
    logic [7:0]  prev_addr = '0;
    logic [31:0] prev_wdata = '0;
    logic [63:0] req_seen = '0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] addi(input logic [4:0] rt, input logic [4:0] rs, input logic [15:0] imm);
        return {6'h08, rs, rt, imm};
    endfunction
    function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction
    function automatic logic [31:0] lw(input logic [4:0] rt, input logic [4:0] base, input logic [15:0] off);
        return {6'h23, base, rt, off};
    endfunction
    function automatic logic [31:0] sw(input logic [4:0] rt, input logic [4:0] base, input logic [15:0] off);
        return {6'h2B, base, rt, off};
    endfunction

    // Memory responder: decides mem_ready for the cycle just after each edge.
    always @(posedge clk) begin
        #1;
        if (reset || !mem_req) begin
            mem_ready = 1'b0;
            wcnt = 0;
        end else if (mem_addr != pc[7:0] && wcnt < data_waits) begin
            mem_ready = 1'b0;
            wcnt++;
        end else begin
            mem_ready = 1'b1;
            wcnt = 0;
        end
    end

    // Mid-cycle monitor: handshake stability, stores, retire scoreboard.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            last_ret   = cyc + 1;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_val("stall_req",   mem_req,   1'b1);
                check_val("stall_addr",  mem_addr,  prev_addr);
                check_val("stall_we",    mem_we,    prev_we);
                check_val("stall_wdata", mem_wdata, prev_wdata);
            end
            if (mem_req) begin
                req_seen[mem_addr[7:2]] = 1'b1;
                if (mem_addr != pc[7:0]) data_reqs++;
            end
            prev_stall = mem_req && !mem_ready;
            prev_addr  = mem_addr;
            prev_we    = mem_we;
            prev_wdata = mem_wdata;
            if (mem_req && mem_ready && mem_we) begin
                mem[mem_addr[7:2]] = mem_wdata;
                if (exp_wa.size() == 0) begin
                    check_val("unexp_write", mem_we, 1'b0);
                end else begin
                    check_val("wr_addr", mem_addr, exp_wa.pop_front());
                    check_val("wr_data", mem_wdata, exp_wd.pop_front());
                end
            end
            if (retire && sb_on) begin
                if (exp_pc.size() == 0) begin
                    check_val("unexp_retire", retire, 1'b0);
                end else begin
                    check_val("retire_pc",  pc, exp_pc.pop_front());
                    check_val("retire_gap", cyc - last_ret, exp_gap.pop_front());
                end
            end
            if (retire) last_ret = cyc;
        end
    end

    task automatic expect_ret(input int p, input int gap);
        exp_pc.push_back(p);
        exp_gap.push_back(gap);
    endtask

    task automatic begin_prog(input int waits);
        reset = 1'b1;
        #1;
        check_val("rst_mem_req", mem_req, 1'b0);
        check_val("rst_mem_we",  mem_we,  1'b0);
        check_val("rst_retire",  retire,  1'b0);
        check_val("rst_halted",  halted,  1'b0);
        check_val("rst_pc",      pc,      32'h0);
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        exp_pc.delete();
        exp_gap.delete();
        exp_wa.delete();
        exp_wd.delete();
        data_reqs  = 0;
        req_seen   = '0;
        data_waits = waits;
        sb_on      = 1'b1;
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic run_prog(input int limit);
        for (int i = 0; i < limit && exp_pc.size() != 0; i++) @(negedge clk);
        check_val("retire_left", exp_pc.size(), 0);
        for (int i = 0; i < 50 && !halted; i++) @(negedge clk);
        check_val("halt_at_end", halted, 1'b1);
        check_val("writes_left", exp_wa.size(), 0);
    endtask

    task automatic check_reg(input string tag, input logic [4:0] idx, input logic [31:0] exp);
        dbg_ra = idx;
        #1;
        check_val(tag, dbg_rd, exp);
    endtask

    logic [5:0]  bop;
    logic [15:0] bval;
    bit          btaken, found;

    initial begin
        #2;
        // Zero-wait ALU sequence; final write to $0 must be dropped.
        begin_prog(0);
        mem[0] = addi(5'd1, 5'd0, 16'd5);
        mem[1] = addi(5'd2, 5'd0, 16'd4);
        mem[2] = rtype(5'd3, 5'd2, 5'd1, 6'h20);
        mem[3] = addi(5'd0, 5'd0, 16'd7);
        expect_ret(0, 4); expect_ret(4, 4); expect_ret(8, 4); expect_ret(12, 4);
        release_reset();
        run_prog(200);
        check_reg("p1_r3", 5'd3, 32'd9);
        check_reg("p1_r1", 5'd1, 32'd5);
        check_reg("p1_r0", 5'd0, 32'd0);
        check_val("p1_pc", pc, 32'h10);

        // Store then load with three wait cycles on each data access.
        begin_prog(3);
        mem[0] = addi(5'd1, 5'd0, 16'h55);
        mem[1] = sw(5'd1, 5'd0, 16'd28);
        mem[2] = lw(5'd2, 5'd0, 16'd28);
        expect_ret(0, 4); expect_ret(4, 7); expect_ret(8, 8);
        exp_wa.push_back(8'h1C); exp_wd.push_back(32'h55);
        release_reset();
        run_prog(300);
        check_reg("p2_r2", 5'd2, 32'h55);
        check_val("p2_mem7", mem[7], 32'h55);

        // beq/bne, taken and not taken.
        for (int k = 0; k < 4; k++) begin
            bop    = (k < 2) ? 6'h04 : 6'h05;
            bval   = (k % 2 == 0) ? 16'd5 : 16'd4;
            btaken = ((k < 2) == (k % 2 == 0));
            begin_prog(0);
            mem[0] = addi(5'd1, 5'd0, 16'd5);
            mem[1] = addi(5'd2, 5'd0, bval);
            mem[2] = {bop, 5'd1, 5'd2, 16'd1};
            mem[3] = addi(5'd4, 5'd0, 16'd1);
            mem[4] = addi(5'd5, 5'd0, 16'd2);
            expect_ret(0, 4); expect_ret(4, 4); expect_ret(8, 3);
            if (!btaken) expect_ret(12, 4);
            expect_ret(16, 4);
            release_reset();
            run_prog(200);
            check_reg("p3_r4", 5'd4, btaken ? 32'd0 : 32'd1);
            check_reg("p3_r5", 5'd5, 32'd2);
        end

        // Jump over 0xC, then signed compare and the remaining R-type ops.
        begin_prog(0);
        mem[0] = addi(5'd1, 5'd0, 16'hFFFF);
        mem[1] = addi(5'd2, 5'd0, 16'd1);
        mem[2] = {6'h02, 26'd4};
        mem[3] = addi(5'd4, 5'd0, 16'd7);
        mem[4] = rtype(5'd3, 5'd1, 5'd2, 6'h2A);
        mem[5] = rtype(5'd5, 5'd2, 5'd1, 6'h22);
        mem[6] = rtype(5'd6, 5'd1, 5'd2, 6'h24);
        mem[7] = rtype(5'd7, 5'd1, 5'd2, 6'h25);
        mem[8] = rtype(5'd8, 5'd2, 5'd1, 6'h2A);
        expect_ret(0, 4); expect_ret(4, 4); expect_ret(8, 3); expect_ret(16, 4);
        expect_ret(20, 4); expect_ret(24, 4); expect_ret(28, 4); expect_ret(32, 4);
        release_reset();
        run_prog(300);
        check_val("p4_skip_0c", req_seen[3], 1'b0);
        check_reg("p4_slt_neg", 5'd3, 32'd1);
        check_reg("p4_r4",      5'd4, 32'd0);
        check_reg("p4_sub",     5'd5, 32'd2);
        check_reg("p4_and",     5'd6, 32'd1);
        check_reg("p4_or",      5'd7, 32'hFFFF_FFFF);
        check_reg("p4_slt_pos", 5'd8, 32'd0);

        // Illegal opcode 0x3F halts; bus and retire stay quiet.
        begin_prog(0);
        mem[0] = addi(5'd1, 5'd0, 16'd3);
        mem[1] = 32'hFC00_0000;
        expect_ret(0, 4);
        release_reset();
        run_prog(200);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_val("p5_req_quiet", mem_req, 1'b0);
            check_val("p5_no_retire", retire, 1'b0);
        end
        check_val("p5_halted", halted, 1'b1);
        check_val("p5_pc", pc, 32'h4);

        // Misaligned lw from 0x1E traps without a data access.
        begin_prog(0);
        mem[0] = addi(5'd1, 5'd0, 16'd2);
        mem[1] = lw(5'd2, 5'd1, 16'd28);
        expect_ret(0, 4);
        release_reset();
        run_prog(200);
        check_val("p6_data_reqs", data_reqs, 0);
        check_reg("p6_r2", 5'd2, 32'd0);
        check_val("p6_pc", pc, 32'h4);

        // Reset while a load is waiting on memory.
        begin_prog(10);
        mem[0] = addi(5'd1, 5'd0, 16'd9);
        mem[1] = lw(5'd2, 5'd0, 16'd28);
        expect_ret(0, 4);
        release_reset();
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mem_req && mem_addr == 8'h1C) begin
                found = 1'b1;
                break;
            end
        end
        check_val("p7_reach_memrd", found, 1'b1);
        @(negedge clk);
        check_reg("p7_r1_before", 5'd1, 32'd9);
        check_val("p7_stalled", mem_ready, 1'b0);
        check_val("p7_retire_left", exp_pc.size(), 0);
        sb_on = 1'b0;
        #2 reset = 1'b1;
        #1;
        check_val("p7_req_drop", mem_req, 1'b0);
        check_val("p7_we_drop",  mem_we,  1'b0);
        check_val("p7_pc",       pc,      32'h0);
        check_reg("p7_r1_clear", 5'd1, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_val("p7_idle_req", mem_req, 1'b0);
        @(negedge clk);
        check_val("p7_fetch_req",  mem_req,  1'b1);
        check_val("p7_fetch_addr", mem_addr, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mips_multicycle_core.md
Name: mips_multicycle_core

Overview:
Multi-cycle MIPS-subset CPU core. It succeeds the single-cycle datapath with an FSM-sequenced datapath that shares one ALU and one unified instruction/data memory port. That port uses a req/ready handshake, so memories with wait states are supported. The core adds signed slt, bne, alignment and illegal-opcode traps, a retire strobe and a debug register read port. It sits between the top-level wrapper and a single unified memory.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
ADDR_W, 8, byte-address width driven on mem_addr; low ADDR_W bits of the 32-bit address, upper bits dropped
TRAP_ON_ILLEGAL, 1, 1 = unknown opcode/funct halts the core; 0 = executes as a no-op and retires

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
mem_req  out  1  memory access request
mem_we  out  1  write qualifier; valid only while mem_req=1
mem_addr  out  ADDR_W  byte address, always word-aligned
mem_wdata  out  32  store data
mem_rdata  in  32  read data; sampled in the cycle mem_ready=1
mem_ready  in  1  access completes in a cycle with mem_req=1 and mem_ready=1
pc  out  32  address of the instruction currently executing
retire  out  1  one-cycle pulse in the final cycle of each instruction
halted  out  1  sticky trap indicator
dbg_ra  in  5  debug register select
dbg_rd  out  32  combinational read of register dbg_ra; reads 0 when dbg_ra=0

Behaviour:
- Reset (asynchronous):
  - pc=RESET_PC, state=IDLE, halted=0, all 32 registers cleared.
  - mem_req, mem_we and retire drop in the same cycle reset asserts, including mid-access.
  - IDLE lasts exactly one cycle after reset deasserts, then the FSM goes to FETCH.
- FSM states: IDLE, FETCH, DECODE, EXEC_R, EXEC_I, MEMADR, MEMRD, MEMWR, WB_ALU, WB_MEM, BRANCH, JUMP, TRAP.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=pc.
  - Stays in FETCH while mem_ready=0.
  - On ready: IR<=mem_rdata, go to DECODE.
- DECODE: read rs and rt into A and B; ALUOut<=pc+4+(signimm<<2). Next state by opcode:
  - 0x00 -> EXEC_R
  - 0x08 -> EXEC_I
  - 0x23 / 0x2B -> MEMADR
  - 0x04 / 0x05 -> BRANCH
  - 0x02 -> JUMP
  - anything else -> illegal handling
- EXEC_R: funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed). Any other funct is illegal. Next state WB_ALU, which writes rd.
- EXEC_I: A+signimm. Next state WB_ALU, which writes rt.
- MEMADR: addr=A+signimm. If addr[1:0]!=0, go to TRAP. Otherwise go to MEMRD (lw) or MEMWR (sw).
- MEMRD: hold req and address until ready; capture data; go to WB_MEM, which writes rt.
- MEMWR: mem_we=1, mem_wdata=B; hold until ready. The instruction retires in the ready cycle.
- BRANCH: compute A-B. Take the branch when zero (beq) or nonzero (bne).
  - Taken: pc<=ALUOut.
  - Not taken: pc<=pc+4.
  - Retires.
- JUMP: pc<={pc_plus4[31:28], IR[25:0], 2'b00}. Retires.
- Every other retiring state also sets pc<=pc+4.
- mem_addr, mem_we and mem_wdata must not change while mem_req=1 and mem_ready=0.
- Latency with zero-wait memory (mem_ready tied high), counted from entering FETCH:
  - beq / bne / j: 3 cycles
  - R-type, addi, sw: 4 cycles
  - lw: 5 cycles
- Each cycle of mem_ready=0 during an access adds one cycle.
- Register file: writes to $0 are discarded. Writes occur at the clock edge that ends WB_ALU or WB_MEM.
- Arithmetic: 32-bit modulo, no overflow exception. pc wraps modulo 2^32.
- Illegal opcode or funct:
  - TRAP_ON_ILLEGAL=1: go to TRAP. TRAP sets halted=1 and holds mem_req=0 and retire=0 until reset.
  - TRAP_ON_ILLEGAL=0: the instruction retires with no register or memory effect.
- A misaligned lw/sw always goes to TRAP regardless of TRAP_ON_ILLEGAL. No memory access is issued.
- retire never asserts in IDLE or TRAP.

Decomposition:
- Package mips_pkg holds:
  - opcode constants (R, ADDI, LW, SW, BEQ, BNE, J)
  - funct constants
  - the 3-bit ALU-op encoding (add 010, sub 110, and 000, or 001, slt 111)
  - the FSM state enum
- One natural sub-module: mips_mc_fsm (state register plus control decode).
- The datapath, register file and ALU remain in the core.

Test Plan:
- Zero-wait ALU sequence: addi $1,$0,5; addi $2,$0,4; add $3,$2,$1 -> dbg $3=9; retire pulses 4 cycles apart; pc=0xC after the third retire.
- Store/load with waits: addi $1,$0,0x55; sw $1,28($0); lw $2,28($0); mem_ready low for 3 cycles on each data access -> mem_addr=0x1C, mem_wdata=0x55 and mem_we=1 held stable throughout the store; $2=0x55; lw takes 8 cycles.
- Branch pair: $1=$2=5.
  - beq $1,$2,+1 at 0x8 -> next fetch at 0x10.
  - With $2=4 -> next fetch at 0xC.
  - bne mirrors both cases.
- Jump and signed compare:
  - j 4 at 0x8 -> next fetch at 0x10; the word at 0xC is never requested.
  - slt $3 with $1=-1, $2=1 -> $3=1.
- Traps:
  - opcode 0x3F with TRAP_ON_ILLEGAL=1 -> halted=1; mem_req stays 0 for 20 cycles; no retire.
  - lw from address 0x1E -> TRAP with no memory request issued.
- Mid-access reset: assert reset while MEMRD is waiting -> mem_req=0 in the same cycle, pc=RESET_PC, dbg $1=0. After deassert: one IDLE cycle, then a fetch at RESET_PC.
